// File: rtl/bus_arbiter_rr.sv
// Round-robin owner arbiter for the shared internal bus: one-hot grant plus mux select, one-cycle turnaround gap.
// Optional forced release of an owner after HOLD_MAX busy cycles when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter_rr #(
  parameter int N_REQ    = 32,
  parameter int SEL_W    = 5,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] s,
  output logic             bus_busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [SEL_W:0] NR = (SEL_W + 1)'(N_REQ);

  if (SEL_W != $clog2(N_REQ) || HOLD_MAX < 2) begin : g_bad_params
    $error("bus_arbiter_rr: SEL_W must be clog2(N_REQ) and HOLD_MAX at least 2");
  end

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [SEL_W-1:0] s_reg, s_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic             busy_reg, busy_next;
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off, winner;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX) + 1;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              timeout_reg, timeout_next;
`endif

  // Index addition modulo N_REQ, valid for any N_REQ, not only powers of two.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b);
    logic [SEL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= NR) sum = sum - NR;
    return sum[SEL_W-1:0];
  endfunction

  // rot[0] is the requester at ptr, so the lowest set bit of rot is the cyclic winner.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot[gi] = req[wrap_add(ptr_reg, SEL_W'(gi))];
  end

  always_comb begin
    off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = SEL_W'(j);
    end
    winner = wrap_add(ptr_reg, off);
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    s_next     = s_reg;
    grant_next = grant_reg;
    busy_next  = busy_reg;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_next    = hold_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      BUSY: begin
        if (!req[s_reg]) begin
          grant_next = '0;
          busy_next  = 1'b0;
          state_next = GAP;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_reg == HOLD_W'(HOLD_MAX - 1)) begin
          grant_next   = '0;
          busy_next    = 1'b0;
          timeout_next = 1'b1;
          state_next   = GAP;
        end else begin
          hold_next = hold_reg + HOLD_W'(1);
        end
`endif
      end
      default: begin
        // IDLE and GAP arbitrate identically; GAP only differs by having just lost an owner.
        if (|req) begin
          grant_next         = '0;
          grant_next[winner] = 1'b1;
          s_next             = winner;
          busy_next          = 1'b1;
          ptr_next           = wrap_add(winner, SEL_W'(1));
          state_next         = BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_next = '0;
`endif
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      s_reg     <= '0;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      s_reg     <= s_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_reg    <= hold_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

  assign grant    = grant_reg;
  assign s        = s_reg;
  assign bus_busy = busy_reg;
`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

endmodule
